// File: rtl/branch_ctrl.sv
// Branch/jump controller: holds the ALU flag register, evaluates one branch request
// at a time, and on a taken branch issues a PC load pulse plus a timed pipeline flush.
module branch_ctrl #(
  parameter int ADDR_W       = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flag_we,
  input  logic              zf_in,
  input  logic              nf_in,
  input  logic              cf_in,
  input  logic              of_in,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic              br_always,
  input  logic [ADDR_W-1:0] br_target,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush,
  output logic [3:0]        flags_q,
  output logic [7:0]        taken_cnt,
  output logic [1:0]        dbg_state
);

  // Handshake: a request transfers on any rising edge where br_valid and br_ready are
  // both high; br_ready depends only on state, never on br_valid.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(FLUSH_CYCLES - 1);

  state_e              state_q, state_d;
  logic [2:0]          cond_q, cond_d;
  logic                always_q, always_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic [3:0]          flags_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          taken_cnt_q, taken_cnt_d;
  logic                taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cond_q      <= '0;
      always_q    <= 1'b0;
      target_q    <= '0;
      flags_q     <= '0;
      cnt_q       <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cond_q      <= cond_d;
      always_q    <= always_d;
      target_q    <= target_d;
      flags_q     <= flags_d;
      cnt_q       <= cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cond_d      = cond_q;
    always_d    = always_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    taken_cnt_d = taken_cnt_q;
    taken       = 1'b0;
    // Flag writes are independent of the FSM; EVAL sees the registered value only.
    flags_d     = flag_we ? {of_in, cf_in, nf_in, zf_in} : flags_q;

    case (state_q)
      IDLE: begin
        if (br_valid) begin
          cond_d   = br_cond;
          always_d = br_always;
          target_d = br_target;
          state_d  = EVAL;
        end
      end
      EVAL: begin
        taken = always_q | (flags_q[cond_q[1:0]] ^ cond_q[2]);
        if (taken) begin
          state_d = FLUSH;
          cnt_d   = '0;
          if (taken_cnt_q != 8'hFF) taken_cnt_d = taken_cnt_q + 8'd1;
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign br_ready  = (state_q == IDLE);
  assign flush     = (state_q == FLUSH);
  assign pc_load   = (state_q == FLUSH) && (cnt_q == 4'd0);
  assign pc_target = target_q;
  assign taken_cnt = taken_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: table vectors, directed corner sequences and random traffic
// checked every cycle against a cycle-schedule reference model.
module tb_branch_ctrl;

  localparam int AW = 8;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flag_we, zf_in, nf_in, cf_in, of_in;
  logic          br_valid, br_ready, br_always;
  logic [2:0]    br_cond;
  logic [AW-1:0] br_target, pc_target;
  logic          pc_load, flush;
  logic [3:0]    flags_q;
  logic [7:0]    taken_cnt;
  logic [1:0]    dbg_state;

  branch_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .flag_we(flag_we),
    .zf_in(zf_in), .nf_in(nf_in), .cf_in(cf_in), .of_in(of_in),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
    .br_always(br_always), .br_target(br_target), .pc_load(pc_load),
    .pc_target(pc_target), .flush(flush), .flags_q(flags_q),
    .taken_cnt(taken_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks cycle numbers at which each output event is due.
  int         cyc;
  int         ready_at, eval_cyc, load_cyc, flush_end;
  logic [2:0] m_cond;
  logic       m_alw;
  logic [7:0] m_target;
  logic [3:0] m_flags;
  int         m_cnt;

  task automatic model_reset();
    ready_at = 0; eval_cyc = -1; load_cyc = -1; flush_end = -2;
    m_cond = '0; m_alw = 1'b0; m_target = '0; m_flags = '0; m_cnt = 0;
  endtask

  logic       s_ready, s_load, s_flush;
  logic [7:0] s_target, s_cnt;

  // Entered at posedge+1: drive a cycle, check mid-cycle, advance model, wait next edge.
  task automatic step(input logic we, input logic [3:0] fl, input logic v,
                      input logic [2:0] c, input logic a, input logic [7:0] t);
    logic e_ready, tk;
    flag_we = we; {of_in, cf_in, nf_in, zf_in} = fl;
    br_valid = v; br_cond = c; br_always = a; br_target = t;
    #4;
    e_ready = (cyc >= ready_at);
    s_ready = br_ready; s_load = pc_load; s_flush = flush;
    s_target = pc_target; s_cnt = taken_cnt;
    chk("br_ready", br_ready, e_ready);
    chk("pc_load", pc_load, cyc == load_cyc);
    chk("flush", flush, (cyc >= load_cyc) && (cyc <= flush_end));
    chk("pc_target", pc_target, m_target);
    chk("flags_q", flags_q, m_flags);
    chk("taken_cnt", taken_cnt, m_cnt);
    if (eval_cyc == cyc) begin
      tk = m_alw | (((m_flags >> m_cond[1:0]) & 4'd1) != 0) ^ m_cond[2];
      if (tk) begin
        load_cyc = cyc + 1; flush_end = cyc + FC; ready_at = cyc + 1 + FC;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end else begin
        ready_at = cyc + 1;
      end
      eval_cyc = -1;
    end
    if (e_ready && v) begin
      m_cond = c; m_alw = a; m_target = t;
      eval_cyc = cyc + 1; ready_at = 32'h7fff_ffff;
    end
    if (we) m_flags = fl;
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 1'b0, 3'b000, 1'b0, 8'h00);
  endtask

  // Run idle cycles until br_ready returns; reports pc_load pulses seen.
  task automatic drain(output int loads);
    bit done = 0;
    loads = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      idle();
      loads += int'(s_load);
      if (s_ready) done = 1;
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ready", br_ready, 1); chk("rst_load", pc_load, 0);
    chk("rst_flush", flush, 0);    chk("rst_target", pc_target, 0);
    chk("rst_flags", flags_q, 0);  chk("rst_cnt", taken_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [3:0] fl;
    logic [2:0] cond;
    logic       alw;
    logic       exp_taken;
  } vec_t;

  vec_t vecs[9];
  int   loads;

  initial begin
    vecs[0] = '{4'b0001, 3'b000, 1'b0, 1'b1};
    vecs[1] = '{4'b0000, 3'b000, 1'b0, 1'b0};
    vecs[2] = '{4'b0000, 3'b100, 1'b0, 1'b1};
    vecs[3] = '{4'b0010, 3'b001, 1'b0, 1'b1};
    vecs[4] = '{4'b0100, 3'b010, 1'b0, 1'b1};
    vecs[5] = '{4'b1011, 3'b010, 1'b0, 1'b0};
    vecs[6] = '{4'b1000, 3'b111, 1'b0, 1'b0};
    vecs[7] = '{4'b0000, 3'b011, 1'b1, 1'b1};
    vecs[8] = '{4'b1111, 3'b110, 1'b0, 1'b0};

    cyc = 0;
    model_reset();
    flag_we = 0; {of_in, cf_in, nf_in, zf_in} = '0;
    br_valid = 0; br_cond = '0; br_always = 0; br_target = '0;
    @(posedge clk); #1;
    do_reset();

    // Conditional taken on Z=1
    step(1'b1, 4'b0001, 1'b0, 3'b000, 1'b0, 8'h00);
    step(1'b0, 4'b0000, 1'b1, 3'b000, 1'b0, 8'h3C);
    step(1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 8'h00);
    chk("ct_c1_ready", s_ready, 0);
    idle();
    chk("ct_c2_load", s_load, 1);   chk("ct_c2_target", s_target, 8'h3C);
    chk("ct_c2_flush", s_flush, 1); chk("ct_c2_cnt", s_cnt, 1);
    idle();
    chk("ct_c3_flush", s_flush, 1); chk("ct_c3_load", s_load, 0);
    chk("ct_c3_ready", s_ready, 0);
    idle();
    chk("ct_c4_ready", s_ready, 1); chk("ct_c4_flush", s_flush, 0);

    // Not taken on C=0
    step(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0, 8'h00);
    step(1'b0, 4'b0000, 1'b1, 3'b010, 1'b0, 8'h77);
    idle();
    idle();
    chk("nt_c2_ready", s_ready, 1); chk("nt_c2_load", s_load, 0);
    chk("nt_c2_flush", s_flush, 0); chk("nt_c2_cnt", s_cnt, 1);

    // Invert with flag write in the accept cycle: new N=0 inverted -> taken
    step(1'b1, 4'b0010, 1'b0, 3'b000, 1'b0, 8'h00);
    step(1'b1, 4'b0000, 1'b1, 3'b101, 1'b0, 8'h11);
    drain(loads);
    chk("hz_accept_taken", loads, 1);
    // Flag write in EVAL: old N=1 inverted -> not taken
    step(1'b1, 4'b0010, 1'b0, 3'b000, 1'b0, 8'h00);
    step(1'b0, 4'b0000, 1'b1, 3'b101, 1'b0, 8'h22);
    step(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0, 8'h00);
    idle();
    chk("hz_eval_load", s_load, 0); chk("hz_eval_ready", s_ready, 1);

    // Unconditional jump with br_valid held through the busy window
    step(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0, 8'h00);
    for (int k = 0; k <= 2 + FC; k++) begin
      step(1'b0, 4'b0000, 1'b1, 3'b000, 1'b1, 8'h55);
      if (k >= 1 && k <= 1 + FC) chk("uj_busy_ready", s_ready, 0);
      if (k == 2) chk("uj_load", s_load, 1);
      if (k == 2 + FC) chk("uj_ready_back", s_ready, 1);
    end
    drain(loads);
    chk("uj_second_taken", loads, 1);

    // Table vectors
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].fl, 1'b0, 3'b000, 1'b0, 8'h00);
      step(1'b0, 4'h0, 1'b1, vecs[i].cond, vecs[i].alw, 8'($urandom_range(0, 255)));
      drain(loads);
      chk($sformatf("vec%0d_taken", i), loads, vecs[i].exp_taken);
    end

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 3, 4'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
           $urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)));
    end
    drain(loads);

    // Saturation
    for (int i = 0; i < 260; i++) begin
      step(1'b0, 4'h0, 1'b1, 3'b000, 1'b1, 8'h9A);
      drain(loads);
    end
    chk("sat_cnt", taken_cnt, 255);
    step(1'b0, 4'h0, 1'b1, 3'b000, 1'b1, 8'h9B);
    drain(loads);
    chk("sat_hold", taken_cnt, 255);

    // Reset asserted mid-FLUSH (cycle 2 of a taken branch)
    step(1'b1, 4'b0001, 1'b0, 3'b000, 1'b0, 8'h00);
    step(1'b0, 4'h0, 1'b1, 3'b000, 1'b0, 8'hC3);
    idle();
    flag_we = 0; br_valid = 0;
    #4;
    chk("mr_pre_load", pc_load, 1);
    chk("mr_pre_flush", flush, 1);
    rst = 1'b1;
    #1;
    chk("mr_ready", br_ready, 1); chk("mr_load", pc_load, 0);
    chk("mr_flush", flush, 0);    chk("mr_target", pc_target, 0);
    chk("mr_flags", flags_q, 0);  chk("mr_cnt", taken_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cyc++;
    idle();
    chk("mr_next_ready", s_ready, 1);
    chk("mr_next_cnt", s_cnt, 0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
